bcd_result_receiver: RTL and testbench

BCD_RESULT_RECEIVER -- requirements
Module: bcd_result_receiver

---
 rtl/bcd_link_pkg.sv | 24 ++
 rtl/bcd_digit_check.sv | 28 ++
 rtl/bcd_result_receiver.sv | 120 ++++++++++++
 tb/tb_bcd_result_receiver.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/bcd_link_pkg.sv
// ---------------------------------------------------------------------------
// bcd_link_pkg : framing constants and FSM state type for the BCD serial link
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package bcd_link_pkg;

  localparam logic [7:0] RESULT_HEADER  = 8'h96;
  localparam logic [7:0] COMMAND_HEADER = 8'h5A;
  localparam int         PAYLOAD_BITS   = 20;

  typedef enum logic {
    HUNT    = 1'b0,
    COLLECT = 1'b1
  } link_state_t;

  function automatic logic nibble_is_bcd(input logic [3:0] nib);
    return (nib <= 4'd9);
  endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_digit_check.sv
// ---------------------------------------------------------------------------
// bcd_digit_check : flags whether every nibble of a word is a legal BCD digit
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module bcd_digit_check
  import bcd_link_pkg::*;
#(
  parameter int WIDTH = 20
) (
  input  logic [WIDTH-1:0] digits,
  output logic             all_digits_valid
);

  localparam int NIBBLES = WIDTH / 4;

  logic [NIBBLES-1:0] w_nib_ok;

  for (genvar g = 0; g < NIBBLES; g++) begin : g_nib
    assign w_nib_ok[g] = nibble_is_bcd(digits[4*g +: 4]);
  end

  assign all_digits_valid = &w_nib_ok;

endmodule

`default_nettype wire

// File: rtl/bcd_result_receiver.sv
// ---------------------------------------------------------------------------
// bcd_result_receiver : deserialises header-framed BCD results into a
//                       valid/ready holding register
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module bcd_result_receiver #(
  parameter logic [7:0] HEADER       = bcd_link_pkg::RESULT_HEADER,
  parameter int         PAYLOAD_BITS = bcd_link_pkg::PAYLOAD_BITS
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    din,
  output logic [PAYLOAD_BITS-1:0] out_result,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    digit_error,
  output logic                    overrun,
  output logic [7:0]              frame_count
);

  import bcd_link_pkg::*;

  localparam int               CNT_W    = $clog2(PAYLOAD_BITS);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(PAYLOAD_BITS - 1);

  link_state_t r_state;
  link_state_t w_state_next;

  // Only the seven newest header bits are stored; din completes the byte.
  logic [6:0]              r_hdr;
  logic [PAYLOAD_BITS-2:0] r_payload;
  logic [CNT_W-1:0]        r_cnt;

  logic [7:0]              w_hdr_byte;
  logic                    w_hdr_match;
  logic [PAYLOAD_BITS-1:0] w_frame;
  logic                    w_done;
  logic                    w_digits_ok;
  logic                    w_accept;

  assign w_hdr_byte  = {r_hdr, din};
  assign w_hdr_match = (r_state == HUNT) && (w_hdr_byte == HEADER);
  assign w_frame     = {r_payload, din};
  assign w_done      = (r_state == COLLECT) && (r_cnt == LAST_BIT);
  assign w_accept    = w_done && w_digits_ok && (!out_valid || out_ready);

  bcd_digit_check #(
    .WIDTH (PAYLOAD_BITS)
  ) u_digit_check (
    .digits           (w_frame),
    .all_digits_valid (w_digits_ok)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= HUNT;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      HUNT:    if (w_hdr_match) w_state_next = COLLECT;
      COLLECT: if (w_done)      w_state_next = HUNT;
      default:                  w_state_next = HUNT;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_hdr       <= '0;
      r_payload   <= '0;
      r_cnt       <= '0;
      out_result  <= '0;
      out_valid   <= 1'b0;
      digit_error <= 1'b0;
      overrun     <= 1'b0;
      frame_count <= 8'h00;
    end else begin
      digit_error <= 1'b0;
      overrun     <= 1'b0;

      if (r_state == HUNT) begin
        r_hdr <= w_hdr_byte[6:0];
        if (w_hdr_match) begin
          r_cnt <= '0;
        end
      end else begin
        r_payload <= w_frame[PAYLOAD_BITS-2:0];
        r_cnt     <= r_cnt + 1'b1;
        // Clearing here lets the next header be found from the very next bit.
        if (w_done) begin
          r_hdr <= '0;
        end
      end

      if (w_done && !w_digits_ok) begin
        digit_error <= 1'b1;
      end
      if (w_done && w_digits_ok && out_valid && !out_ready) begin
        overrun <= 1'b1;
      end

      if (w_accept) begin
        out_result  <= w_frame;
        out_valid   <= 1'b1;
        frame_count <= frame_count + 8'h01;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_bcd_result_receiver.sv
// ---------------------------------------------------------------------------
// tb_bcd_result_receiver : directed, table-driven bench for bcd_result_receiver
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_bcd_result_receiver;

  logic        clock;
  logic        reset;
  logic        din;
  logic [19:0] out_result;
  logic        out_valid;
  logic        out_ready;
  logic        digit_error;
  logic        overrun;
  logic [7:0]  frame_count;

  int checks;
  int failures;
  int pulse_seen;
  bit mon_en;

  bcd_result_receiver dut (
    .clock       (clock),
    .reset       (reset),
    .din         (din),
    .out_result  (out_result),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .digit_error (digit_error),
    .overrun     (overrun),
    .frame_count (frame_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (mon_en && (digit_error || overrun)) pulse_seen++;
  end

  typedef struct {
    logic [19:0] payload;
    logic        rdy_body;
    logic        rdy_last;
    logic [19:0] exp_res;
    logic        exp_v;
    logic        exp_de;
    logic        exp_ov;
    logic [7:0]  exp_fc;
  } vec_t;

  vec_t vecs[10];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    din       = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic send_bits(input logic [31:0] val, input int n, input logic rdy);
    for (int i = n - 1; i >= 0; i--) begin
      din       = val[i];
      out_ready = rdy;
      tick();
    end
  endtask

  task automatic send_frame(input logic [19:0] p, input logic rb, input logic rl);
    send_bits(32'h96, 8, rb);
    send_bits({12'h000, p} >> 1, 19, rb);
    send_bits({31'h0, p[0]}, 1, rl);
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    pulse_seen = 0;
    mon_en     = 1'b0;

    //          payload   rb    rl    exp_res   v     de    ov    fc
    vecs[0] = '{20'h12345, 1'b1, 1'b1, 20'h12345, 1'b1, 1'b0, 1'b0, 8'd1};
    vecs[1] = '{20'h10000, 1'b0, 1'b1, 20'h10000, 1'b1, 1'b0, 1'b0, 8'd2};
    vecs[2] = '{20'h00042, 1'b0, 1'b0, 20'h10000, 1'b1, 1'b0, 1'b1, 8'd2};
    vecs[3] = '{20'h0A000, 1'b0, 1'b0, 20'h10000, 1'b1, 1'b1, 1'b0, 8'd2};
    vecs[4] = '{20'h0A000, 1'b1, 1'b1, 20'h10000, 1'b0, 1'b1, 1'b0, 8'd2};
    vecs[5] = '{20'h00009, 1'b0, 1'b0, 20'h00009, 1'b1, 1'b0, 1'b0, 8'd3};
    vecs[6] = '{20'h99999, 1'b0, 1'b0, 20'h00009, 1'b1, 1'b0, 1'b1, 8'd3};
    vecs[7] = '{20'h96969, 1'b0, 1'b1, 20'h96969, 1'b1, 1'b0, 1'b0, 8'd4};
    vecs[8] = '{20'hF0000, 1'b1, 1'b1, 20'h96969, 1'b0, 1'b1, 1'b0, 8'd4};
    vecs[9] = '{20'h00000, 1'b0, 1'b0, 20'h00000, 1'b1, 1'b0, 1'b0, 8'd5};

    // Reset state
    do_reset();
    chk("reset out_result", {12'h0, out_result}, 32'h0);
    chk("reset out_valid", {31'h0, out_valid}, 32'h0);
    chk("reset digit_error", {31'h0, digit_error}, 32'h0);
    chk("reset overrun", {31'h0, overrun}, 32'h0);
    chk("reset frame_count", {24'h0, frame_count}, 32'h0);

    // Idle zeros, then one frame, consumer always ready
    send_bits(32'h0, 13, 1'b1);
    send_frame(20'h12345, 1'b1, 1'b1);
    chk("basic valid", {31'h0, out_valid}, 32'h1);
    chk("basic result", {12'h0, out_result}, 32'h12345);
    chk("basic count", {24'h0, frame_count}, 32'h1);
    send_bits(32'h0, 1, 1'b1);
    chk("basic valid drops", {31'h0, out_valid}, 32'h0);

    // Table: stateful sequence of frames
    do_reset();
    for (int i = 0; i < 10; i++) begin
      send_frame(vecs[i].payload, vecs[i].rdy_body, vecs[i].rdy_last);
      chk($sformatf("vec%0d result", i), {12'h0, out_result}, {12'h0, vecs[i].exp_res});
      chk($sformatf("vec%0d valid", i), {31'h0, out_valid}, {31'h0, vecs[i].exp_v});
      chk($sformatf("vec%0d digit_error", i), {31'h0, digit_error}, {31'h0, vecs[i].exp_de});
      chk($sformatf("vec%0d overrun", i), {31'h0, overrun}, {31'h0, vecs[i].exp_ov});
      chk($sformatf("vec%0d count", i), {24'h0, frame_count}, {24'h0, vecs[i].exp_fc});
      send_bits(32'h0, 1, 1'b0);
      chk($sformatf("vec%0d pulses end", i), {30'h0, digit_error, overrun}, 32'h0);
      chk($sformatf("vec%0d valid kept", i), {31'h0, out_valid}, {31'h0, vecs[i].exp_v});
    end

    // Misaligned prefix ahead of the true header
    do_reset();
    send_bits(32'h4B, 8, 1'b0);
    send_frame(20'h31415, 1'b0, 1'b0);
    chk("align result", {12'h0, out_result}, 32'h31415);
    chk("align valid", {31'h0, out_valid}, 32'h1);
    chk("align count", {24'h0, frame_count}, 32'h1);

    // Reset in mid-payload discards the partial frame silently
    do_reset();
    pulse_seen = 0;
    mon_en     = 1'b1;
    send_bits(32'h96, 8, 1'b0);
    send_bits(32'h3FF, 10, 1'b0);
    reset = 1'b1;
    din   = 1'b0;
    tick();
    reset = 1'b0;
    send_frame(20'h00500, 1'b0, 1'b0);
    tick();
    mon_en = 1'b0;
    chk("midreset pulses", pulse_seen, 0);
    chk("midreset result", {12'h0, out_result}, 32'h00500);
    chk("midreset count", {24'h0, frame_count}, 32'h1);

    // Reset on the completing edge wins
    do_reset();
    send_bits(32'h96, 8, 1'b1);
    send_bits(32'h12345 >> 1, 19, 1'b1);
    reset = 1'b1;
    din   = 1'b1;
    tick();
    reset = 1'b0;
    chk("resetwin valid", {31'h0, out_valid}, 32'h0);
    chk("resetwin count", {24'h0, frame_count}, 32'h0);
    chk("resetwin result", {12'h0, out_result}, 32'h0);

    // frame_count wraps after 256 loads
    do_reset();
    for (int k = 0; k < 256; k++) send_frame(20'h00001, 1'b1, 1'b1);
    chk("wrap count", {24'h0, frame_count}, 32'h0);
    chk("wrap result", {12'h0, out_result}, 32'h00001);
    send_frame(20'h00002, 1'b1, 1'b1);
    chk("wrap count next", {24'h0, frame_count}, 32'h1);
    chk("wrap result next", {12'h0, out_result}, 32'h00002);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
